spio_hss_multiplexer_link_supervisor: RTL and testbench
=======================================================

Name: spio_hss_multiplexer_link_supervisor

Overview:
Sequences bring-up and recovery of one HSS multiplexer link.
- Holds the transceiver RX path in reset until the PLL is locked, then lets it settle.
- Waits for the rx control block to report handshake completion, with a timeout and automatic retry.
- Supervises the established link and reports state, link drops and persistent faults to the top level and status registers.

Parameters:
RESET_HOLD, 16, cycles RXRESET_OUT held high once PLL_LOCKED_IN is high (>=1)
SETTLE_CYCLES, 1024, cycles after reset release before handshake timing starts (>=1)
HANDSHAKE_TIMEOUT, 1000000, cycles allowed in HANDSHAKE before retry (>=1)
TIMER_BITS, 20, timer width; must hold max(RESET_HOLD, SETTLE_CYCLES, HANDSHAKE_TIMEOUT)-1
MAX_RETRIES, 7, consecutive timeouts before LINK_FAULT_OUT asserts (>=1)
RETRY_BITS, 3, width able to hold MAX_RETRIES
DROP_BITS, 16, width of the link-drop counter

Ports:
CLK_IN  input  1  clock
RESET_IN  input  1  synchronous, active-high reset
PLL_LOCKED_IN  input  1  transceiver PLL lock
RXLOSSOFSYNC_IN  input  2  transceiver loss-of-sync status; bit 1 = sync lost
HANDSHAKE_COMPLETE_IN  input  1  from rx control
VERSION_MISMATCH_IN  input  1  from rx control
CLEAR_COUNTS_IN  input  1  clears retry and drop counters and VERSION_FAULT_OUT
RXRESET_OUT  output  1  transceiver RX reset request
LINK_UP_OUT  output  1  link usable
STATE_OUT  output  2  0=RESET_HOLD 1=SETTLE 2=HANDSHAKE 3=UP
RETRY_COUNT_OUT  output  RETRY_BITS  consecutive handshake timeouts, saturating
LINK_FAULT_OUT  output  1  RETRY_COUNT_OUT == MAX_RETRIES
DROP_COUNT_OUT  output  DROP_BITS  UP-to-not-UP transitions, saturating at all-ones
VERSION_FAULT_OUT  output  1  sticky: mismatch seen during HANDSHAKE

Behaviour:
Clock and reset:
- Single clock CLK_IN; RESET_IN is synchronous and active-high.
- Reset values: state RESET_HOLD, timer 0, RXRESET_OUT 1, LINK_UP_OUT 0, STATE_OUT 0, all counters 0, LINK_FAULT_OUT 0, VERSION_FAULT_OUT 0.
- Reset mid-operation restores all of these on the next edge.

Output decode:
- RXRESET_OUT = (state==RESET_HOLD).
- LINK_UP_OUT = (state==UP).
- Both are pure decodes of the state register, so there is no extra latency.

Timer:
- One up-counter, cleared on every state change.
- Increments only in RESET_HOLD (and only while PLL_LOCKED_IN is high), SETTLE and HANDSHAKE.

Transitions, evaluated in priority order:
1. !PLL_LOCKED_IN in any state -> RESET_HOLD with timer 0. Count a drop if leaving UP.
2. RXLOSSOFSYNC_IN[1] in HANDSHAKE or UP -> RESET_HOLD. Count a drop if leaving UP.
3. RESET_HOLD with timer==RESET_HOLD-1 -> SETTLE. RXRESET_OUT is therefore high for exactly RESET_HOLD locked cycles.
4. SETTLE with timer==SETTLE_CYCLES-1 -> HANDSHAKE.
5. HANDSHAKE with HANDSHAKE_COMPLETE_IN -> UP. This clears the retry counter.
6. HANDSHAKE with timer==HANDSHAKE_TIMEOUT-1 and completion not yet seen -> RESET_HOLD. Retry counter increments, saturating at MAX_RETRIES.
7. UP with !HANDSHAKE_COMPLETE_IN (remote restarted the handshake) -> HANDSHAKE. Count a drop; no transceiver reset.
- Completion and timeout in the same cycle: completion wins.

Fault persistence:
- Retries continue indefinitely while LINK_FAULT_OUT is high.
- LINK_FAULT_OUT clears only on entry to UP, on CLEAR_COUNTS_IN, or on reset.

Version fault:
- VERSION_FAULT_OUT is set by VERSION_MISMATCH_IN while in HANDSHAKE.
- Cleared only by CLEAR_COUNTS_IN or reset.

Counter arithmetic:
- Counters never wrap.
- DROP_COUNT_OUT holds at 2^DROP_BITS-1.
- CLEAR_COUNTS_IN together with an increment in the same cycle yields 1 (the clear applies first, then the increment).

Decomposition:
- Shared header spio_hss_multiplexer_common.h gains state encoding constants: LS_RESET_HOLD, LS_SETTLE, LS_HANDSHAKE, LS_UP.
- One sub-module: spio_hss_multiplexer_sat_counter (params WIDTH, MAX; inputs INC, CLR, CLR_ALL), instantiated for both the retry and drop counters.
- Timer and FSM stay in this module.

Test Plan:
(Bench parameters: RESET_HOLD=4, SETTLE_CYCLES=8, HANDSHAKE_TIMEOUT=32, MAX_RETRIES=3.)
1. Nominal bring-up: PLL locked at cycle 10 after reset, HANDSHAKE_COMPLETE_IN rises 5 cycles into HANDSHAKE -> RXRESET_OUT high 4 cycles after lock, STATE_OUT sequence 0,1,2,3, LINK_UP_OUT high the cycle after completion.
2. Timeouts: HANDSHAKE_COMPLETE_IN never rises -> after 32 cycles in HANDSHAKE, return to state 0; RETRY_COUNT_OUT steps 1,2,3 then holds; LINK_FAULT_OUT high from the third timeout; a later completion clears both.
3. Remote restart: in UP, drop HANDSHAKE_COMPLETE_IN for 1 cycle -> STATE_OUT=2 with no RXRESET_OUT pulse; DROP_COUNT_OUT=1; reassertion returns to UP.
4. Priority: in UP, assert RXLOSSOFSYNC_IN=2'b10 and deassert PLL_LOCKED_IN together -> state 0, DROP_COUNT_OUT increments once only, timer frozen until relock.
5. Boundary: completion exactly on timer==31 -> goes UP, RETRY_COUNT_OUT unchanged; DROP_BITS=2 forced through 5 drops -> count holds at 3; CLEAR_COUNTS_IN coinciding with a drop -> count becomes 1.
6. VERSION_MISMATCH_IN pulsed in HANDSHAKE -> VERSION_FAULT_OUT stays high through UP; reset mid-HANDSHAKE returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/spio_hss_multiplexer_link_supervisor_pkg.sv
// Shared definitions for the HSS multiplexer link supervisor: state encoding
// and the link-supervisor state type.
package spio_hss_multiplexer_link_supervisor_pkg;

  localparam int unsigned STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    LS_RESET_HOLD = 2'd0,
    LS_SETTLE     = 2'd1,
    LS_HANDSHAKE  = 2'd2,
    LS_UP         = 2'd3
  } ls_state_e;

endpackage

// File: rtl/spio_hss_multiplexer_sat_counter.sv
// Saturating up-counter; clears apply before the increment in the same cycle.
module spio_hss_multiplexer_sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic             INC,
  input  logic             CLR,
  input  logic             CLR_ALL,
  output logic [WIDTH-1:0] COUNT_OUT
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_base;

  always_comb begin
    count_base = count_q;
    if (CLR || CLR_ALL) begin
      count_base = '0;
    end
    count_d = count_base;
    if (INC && (count_base != MAX_VAL)) begin
      count_d = count_base + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT_OUT = count_q;

endmodule

// File: rtl/spio_hss_multiplexer_link_supervisor.sv
// Bring-up and recovery sequencer for one HSS multiplexer link: transceiver
// reset hold, settle, handshake with timeout/retry, and link supervision.
module spio_hss_multiplexer_link_supervisor
  import spio_hss_multiplexer_link_supervisor_pkg::*;
#(
  parameter int unsigned RESET_HOLD        = 16,
  parameter int unsigned SETTLE_CYCLES     = 1024,
  parameter int unsigned HANDSHAKE_TIMEOUT = 1000000,
  parameter int unsigned TIMER_BITS        = 20,
  parameter int unsigned MAX_RETRIES       = 7,
  parameter int unsigned RETRY_BITS        = 3,
  parameter int unsigned DROP_BITS         = 16
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_IN,
  input  logic                  PLL_LOCKED_IN,
  input  logic [1:0]            RXLOSSOFSYNC_IN,
  input  logic                  HANDSHAKE_COMPLETE_IN,
  input  logic                  VERSION_MISMATCH_IN,
  input  logic                  CLEAR_COUNTS_IN,
  output logic                  RXRESET_OUT,
  output logic                  LINK_UP_OUT,
  output logic [1:0]            STATE_OUT,
  output logic [RETRY_BITS-1:0] RETRY_COUNT_OUT,
  output logic                  LINK_FAULT_OUT,
  output logic [DROP_BITS-1:0]  DROP_COUNT_OUT,
  output logic                  VERSION_FAULT_OUT
);

  localparam logic [TIMER_BITS-1:0] HOLD_LAST    = TIMER_BITS'(RESET_HOLD - 1);
  localparam logic [TIMER_BITS-1:0] SETTLE_LAST  = TIMER_BITS'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_BITS-1:0] TIMEOUT_LAST = TIMER_BITS'(HANDSHAKE_TIMEOUT - 1);
  localparam int unsigned           DROP_MAX     = (1 << DROP_BITS) - 1;

  ls_state_e             state_q;
  ls_state_e             state_d;
  logic [TIMER_BITS-1:0] timer_q;
  logic [TIMER_BITS-1:0] timer_d;
  logic                  version_fault_q;
  logic                  version_fault_d;
  logic                  retry_inc;
  logic                  retry_clr;
  logic                  drop_inc;
  logic [RETRY_BITS-1:0] retry_count;
  logic [DROP_BITS-1:0]  drop_count;
  logic                  unused_los_bit0;

  assign unused_los_bit0 = RXLOSSOFSYNC_IN[0];

  // State register, phase timer and sticky version fault.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q         <= LS_RESET_HOLD;
      timer_q         <= '0;
      version_fault_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      version_fault_q <= version_fault_d;
    end
  end

  // Next state in priority order: lock loss, sync loss, then per-state progress.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    if (!PLL_LOCKED_IN) begin
      state_d = LS_RESET_HOLD;
    end else if (RXLOSSOFSYNC_IN[1] && ((state_q == LS_HANDSHAKE) || (state_q == LS_UP))) begin
      state_d = LS_RESET_HOLD;
    end else begin
      case (state_q)
        LS_RESET_HOLD: if (timer_q == HOLD_LAST)   state_d = LS_SETTLE;
        LS_SETTLE:     if (timer_q == SETTLE_LAST) state_d = LS_HANDSHAKE;
        LS_HANDSHAKE: begin
          if (HANDSHAKE_COMPLETE_IN) begin
            state_d = LS_UP;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d   = LS_RESET_HOLD;
            retry_inc = 1'b1;
          end
        end
        LS_UP:         if (!HANDSHAKE_COMPLETE_IN) state_d = LS_HANDSHAKE;
        default:       state_d = LS_RESET_HOLD;
      endcase
    end

    // Timer restarts on any state change and is frozen at zero while unlocked or up.
    timer_d = '0;
    if (PLL_LOCKED_IN && (state_d == state_q) && (state_q != LS_UP)) begin
      timer_d = timer_q + TIMER_BITS'(1);
    end

    retry_clr = (state_q == LS_HANDSHAKE) && (state_d == LS_UP);
    drop_inc  = (state_q == LS_UP) && (state_d != LS_UP);

    version_fault_d = CLEAR_COUNTS_IN ? 1'b0 : version_fault_q;
    if ((state_q == LS_HANDSHAKE) && VERSION_MISMATCH_IN) begin
      version_fault_d = 1'b1;
    end
  end

  // Outputs are decodes of registered state and counters.
  always_comb begin
    RXRESET_OUT       = 1'b0;
    LINK_UP_OUT       = 1'b0;
    STATE_OUT         = state_q;
    RETRY_COUNT_OUT   = retry_count;
    DROP_COUNT_OUT    = drop_count;
    VERSION_FAULT_OUT = version_fault_q;
    LINK_FAULT_OUT    = (retry_count == RETRY_BITS'(MAX_RETRIES));
    if (state_q == LS_RESET_HOLD) RXRESET_OUT = 1'b1;
    if (state_q == LS_UP)         LINK_UP_OUT = 1'b1;
  end

  spio_hss_multiplexer_sat_counter #(
    .WIDTH (RETRY_BITS),
    .MAX   (MAX_RETRIES)
  ) u_retry_counter (
    .CLK_IN    (CLK_IN),
    .RESET_IN  (RESET_IN),
    .INC       (retry_inc),
    .CLR       (retry_clr),
    .CLR_ALL   (CLEAR_COUNTS_IN),
    .COUNT_OUT (retry_count)
  );

  spio_hss_multiplexer_sat_counter #(
    .WIDTH (DROP_BITS),
    .MAX   (DROP_MAX)
  ) u_drop_counter (
    .CLK_IN    (CLK_IN),
    .RESET_IN  (RESET_IN),
    .INC       (drop_inc),
    .CLR       (1'b0),
    .CLR_ALL   (CLEAR_COUNTS_IN),
    .COUNT_OUT (drop_count)
  );

endmodule

// File: tb/tb_spio_hss_multiplexer_link_supervisor.sv
// Scoreboard bench for the link supervisor: stimulus queues cycle-tagged
// expected output snapshots, a negedge monitor pops and compares them.
module tb_spio_hss_multiplexer_link_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll;
  logic [1:0] los;
  logic       hc;
  logic       vm;
  logic       clr;
  logic       rxreset;
  logic       linkup;
  logic [1:0] state;
  logic [1:0] retry;
  logic       fault;
  logic [1:0] drop;
  logic       vfault;

  typedef struct {
    int         cyc;
    logic [9:0] v;
    string      name;
  } exp_t;

  exp_t scb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spio_hss_multiplexer_link_supervisor #(
    .RESET_HOLD        (4),
    .SETTLE_CYCLES     (8),
    .HANDSHAKE_TIMEOUT (32),
    .TIMER_BITS        (6),
    .MAX_RETRIES       (3),
    .RETRY_BITS        (2),
    .DROP_BITS         (2)
  ) dut (
    .CLK_IN                (clk),
    .RESET_IN              (rst),
    .PLL_LOCKED_IN         (pll),
    .RXLOSSOFSYNC_IN       (los),
    .HANDSHAKE_COMPLETE_IN (hc),
    .VERSION_MISMATCH_IN   (vm),
    .CLEAR_COUNTS_IN       (clr),
    .RXRESET_OUT           (rxreset),
    .LINK_UP_OUT           (linkup),
    .STATE_OUT             (state),
    .RETRY_COUNT_OUT       (retry),
    .LINK_FAULT_OUT        (fault),
    .DROP_COUNT_OUT        (drop),
    .VERSION_FAULT_OUT     (vfault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected snapshot k edges from now: {state, rxreset, linkup, retry, fault, drop, vfault}.
  task automatic expect_at(input int k, input string name, input logic [1:0] st,
                           input logic [1:0] rt, input logic [1:0] dr, input logic vf);
    exp_t e;
    e.cyc  = cyc + k;
    e.v    = {st, st == 2'd0, st == 2'd3, rt, rt == 2'd3, dr, vf};
    e.name = name;
    scb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [9:0] act;
    act = {state, rxreset, linkup, retry, fault, drop, vfault};
    while (scb.size() > 0 && scb[0].cyc <= cyc) begin
      checks++;
      if (scb[0].cyc < cyc) begin
        fails++;
        $display("FAIL %s: snapshot for cycle %0d missed at cycle %0d", scb[0].name, scb[0].cyc, cyc);
      end else if (act !== scb[0].v) begin
        fails++;
        $display("FAIL %s @%0d: got {st,rxr,up,rt,flt,dr,vf}=%b, want %b", scb[0].name, cyc, act, scb[0].v);
      end
      void'(scb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; pll = 1'b0; los = 2'b00; hc = 1'b0; vm = 1'b0; clr = 1'b0;
    step(2);
    rst = 1'b0;
    expect_at(0, "reset_values", 2'd0, 2'd0, 2'd0, 1'b0);

    // Nominal bring-up: lock 10 cycles after reset, completion 5 cycles into handshake.
    step(10);
    expect_at(0, "unlocked_hold", 2'd0, 2'd0, 2'd0, 1'b0);
    pll = 1'b1;
    expect_at(3,  "hold_last",   2'd0, 2'd0, 2'd0, 1'b0);
    expect_at(4,  "settle_in",   2'd1, 2'd0, 2'd0, 1'b0);
    expect_at(11, "settle_last", 2'd1, 2'd0, 2'd0, 1'b0);
    expect_at(12, "hs_in",       2'd2, 2'd0, 2'd0, 1'b0);
    step(12);
    step(5);
    hc = 1'b1;
    expect_at(0, "hs_before_done", 2'd2, 2'd0, 2'd0, 1'b0);
    expect_at(1, "up",             2'd3, 2'd0, 2'd0, 1'b0);
    step(1);

    // Remote restart: one-cycle completion drop, no transceiver reset.
    hc = 1'b0;
    expect_at(1, "restart_hs", 2'd2, 2'd0, 2'd1, 1'b0);
    step(1);
    hc = 1'b1;
    expect_at(1, "restart_up", 2'd3, 2'd0, 2'd1, 1'b0);
    step(1);

    // Lock loss and sync loss together count a single drop; timer held while unlocked.
    los = 2'b10; pll = 1'b0; hc = 1'b0;
    expect_at(1, "prio_drop", 2'd0, 2'd0, 2'd2, 1'b0);
    step(1);
    los = 2'b00;
    expect_at(5, "unlocked_frozen", 2'd0, 2'd0, 2'd2, 1'b0);
    step(5);
    pll = 1'b1;
    expect_at(3,  "relock_hold",   2'd0, 2'd0, 2'd2, 1'b0);
    expect_at(4,  "relock_settle", 2'd1, 2'd0, 2'd2, 1'b0);
    expect_at(12, "relock_hs",     2'd2, 2'd0, 2'd2, 1'b0);
    step(12);

    // Handshake timeouts: retry count 1,2,3 then saturates; fault follows.
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] before_rt;
      logic [1:0] after_rt;
      before_rt = (i - 1 > 3) ? 2'd3 : 2'(i - 1);
      after_rt  = (i > 3) ? 2'd3 : 2'(i);
      expect_at(31, "hs_t31",  2'd2, before_rt, 2'd2, 1'b0);
      expect_at(32, "timeout", 2'd0, after_rt,  2'd2, 1'b0);
      step(32);
      expect_at(12, "retry_hs", 2'd2, after_rt, 2'd2, 1'b0);
      step(12);
    end
    step(3);
    hc = 1'b1;
    expect_at(1, "fault_cleared_up", 2'd3, 2'd0, 2'd2, 1'b0);
    step(1);

    // Completion on the last timeout cycle wins over the timeout.
    hc = 1'b0;
    expect_at(1, "restart2", 2'd2, 2'd0, 2'd3, 1'b0);
    step(1);
    expect_at(31, "hs_t31_wait", 2'd2, 2'd0, 2'd3, 1'b0);
    step(31);
    hc = 1'b1;
    expect_at(1, "done_at_t31", 2'd3, 2'd0, 2'd3, 1'b0);
    step(1);

    // Drop counter saturates at all-ones.
    for (int i = 0; i < 2; i++) begin
      hc = 1'b0;
      expect_at(1, "drop_sat_hs", 2'd2, 2'd0, 2'd3, 1'b0);
      step(1);
      hc = 1'b1;
      expect_at(1, "drop_sat_up", 2'd3, 2'd0, 2'd3, 1'b0);
      step(1);
    end

    // Clear coinciding with a drop leaves a count of one.
    hc = 1'b0; clr = 1'b1;
    expect_at(1, "clr_with_drop", 2'd2, 2'd0, 2'd1, 1'b0);
    step(1);
    clr = 1'b0; hc = 1'b1;
    expect_at(1, "clr_drop_up", 2'd3, 2'd0, 2'd1, 1'b0);
    step(1);

    // Version mismatch in handshake is sticky until cleared.
    hc = 1'b0;
    expect_at(1, "hs_for_vm", 2'd2, 2'd0, 2'd2, 1'b0);
    step(1);
    vm = 1'b1;
    expect_at(1, "vm_set", 2'd2, 2'd0, 2'd2, 1'b1);
    step(1);
    vm = 1'b0; hc = 1'b1;
    expect_at(1, "vm_held_up", 2'd3, 2'd0, 2'd2, 1'b1);
    expect_at(5, "vm_sticky",  2'd3, 2'd0, 2'd2, 1'b1);
    step(5);
    clr = 1'b1;
    expect_at(1, "clr_vm", 2'd3, 2'd0, 2'd0, 1'b0);
    step(1);
    clr = 1'b0; vm = 1'b1;
    expect_at(1, "vm_ignored_up", 2'd3, 2'd0, 2'd0, 1'b0);
    step(1);
    vm = 1'b0;

    // Reset in the middle of a handshake.
    hc = 1'b0;
    expect_at(1, "hs_pre_reset", 2'd2, 2'd0, 2'd1, 1'b0);
    step(1);
    vm = 1'b1;
    expect_at(1, "vm_pre_reset", 2'd2, 2'd0, 2'd1, 1'b1);
    step(1);
    vm = 1'b0;
    step(2);
    rst = 1'b1;
    expect_at(1, "reset_mid_hs", 2'd0, 2'd0, 2'd0, 1'b0);
    step(1);
    rst = 1'b0;

    // Sync loss only acts on bit 1, and returns handshake to reset hold.
    expect_at(3,  "post_rst_hold",   2'd0, 2'd0, 2'd0, 1'b0);
    expect_at(4,  "post_rst_settle", 2'd1, 2'd0, 2'd0, 1'b0);
    expect_at(12, "post_rst_hs",     2'd2, 2'd0, 2'd0, 1'b0);
    step(12);
    los = 2'b01;
    expect_at(1, "los_bit0_ignored", 2'd2, 2'd0, 2'd0, 1'b0);
    step(1);
    los = 2'b10;
    expect_at(1, "los_in_hs", 2'd0, 2'd0, 2'd0, 1'b0);
    step(1);
    los = 2'b00;
    step(2);

    checks++;
    if (scb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", scb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
